// File: rtl/pixel_sched_pkg.sv
// Shared constants and encodings for the ping-pong pixel frame scheduler.
package pixel_sched_pkg;

   localparam int PIXELS_DEF = 784;

   typedef logic [1:0] bank_state_t;

   localparam bank_state_t B_EMPTY   = 2'd0;
   localparam bank_state_t B_FILLING = 2'd1;
   localparam bank_state_t B_FULL    = 2'd2;
   localparam bank_state_t B_READING = 2'd3;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_RUN  = 1'b1;

endpackage

// File: rtl/pixel_bank_ram.sv
// Two-bank pixel store: bank select is the address MSB, registered read.
module pixel_bank_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W:0]   waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W:0]   raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**(ADDR_W+1)];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_frame_scheduler.sv
// Ping-pong frame buffer: one bank fills from the pixel stream while the
// other is classified; one infer_start per full bank, freed on infer_done.
module pixel_frame_scheduler
   import pixel_sched_pkg::*;
#(
   parameter int PIXELS = PIXELS_DEF,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              wr_frame_done,
   output logic              infer_start,
   input  logic              infer_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_bank,
   output logic [CNT_W-1:0]  frame_count
);

   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PIXELS - 1);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PIXELS);

   bank_state_t [1:0] bank_q, bank_d;
   logic              wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              rd_bank_q, rd_bank_d;
   logic [0:0]        rstate_q, rstate_d;
   logic              done_q, done_d;
   logic              start_q, start_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rd_ok_q;
   logic [DATA_W-1:0] ram_rdata;
   logic              wr_hs;

   assign wr_ready = ~rst & ~flush &
                     ((bank_q[wr_bank_q] == B_EMPTY) |
                      (bank_q[wr_bank_q] == B_FILLING));
   assign wr_hs = wr_valid & wr_ready;

   // Writer and reader always own different banks, so both may update
   // bank_d in the same cycle without conflict.
   always_comb begin
      bank_d    = bank_q;
      wr_bank_d = wr_bank_q;
      wr_addr_d = wr_addr_q;
      rd_bank_d = rd_bank_q;
      rstate_d  = rstate_q;
      done_d    = 1'b0;
      start_d   = 1'b0;
      cnt_d     = cnt_q;
      if (flush) begin
         bank_d    = {B_EMPTY, B_EMPTY};
         wr_bank_d = 1'b0;
         wr_addr_d = '0;
         rd_bank_d = 1'b0;
         rstate_d  = R_IDLE;
      end else begin
         if (wr_hs) begin
            if (wr_addr_q == LAST) begin
               bank_d[wr_bank_q] = B_FULL;
               wr_addr_d         = '0;
               wr_bank_d         = ~wr_bank_q;
               done_d            = 1'b1;
            end else begin
               bank_d[wr_bank_q] = B_FILLING;
               wr_addr_d         = wr_addr_q + 1'b1;
            end
         end
         unique case (1'b1)
            (rstate_q == R_IDLE) && (bank_q[rd_bank_q] == B_FULL): begin
               bank_d[rd_bank_q] = B_READING;
               start_d           = 1'b1;
               rstate_d          = R_RUN;
            end
            (rstate_q == R_RUN) && infer_done: begin
               bank_d[rd_bank_q] = B_EMPTY;
               rd_bank_d         = ~rd_bank_q;
               cnt_d             = cnt_q + 1'b1;
               rstate_d          = R_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_q    <= {B_EMPTY, B_EMPTY};
         wr_bank_q <= 1'b0;
         wr_addr_q <= '0;
         rd_bank_q <= 1'b0;
         rstate_q  <= R_IDLE;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         cnt_q     <= '0;
         rd_ok_q   <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         wr_bank_q <= wr_bank_d;
         wr_addr_q <= wr_addr_d;
         rd_bank_q <= rd_bank_d;
         rstate_q  <= rstate_d;
         done_q    <= done_d;
         start_q   <= start_d;
         cnt_q     <= cnt_d;
         rd_ok_q   <= (rd_addr < LIMIT);
      end
   end

   pixel_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_hs),
      .waddr_i ({wr_bank_q, wr_addr_q}),
      .wdata_i (wr_data),
      .raddr_i ({rd_bank_q, rd_addr}),
      .rdata_o (ram_rdata)
   );

   // rd_ok_q also holds rd_data at zero straight out of reset.
   assign rd_data       = rd_ok_q ? ram_rdata : '0;
   assign wr_frame_done = done_q;
   assign infer_start   = start_q;
   assign rd_bank       = rd_bank_q;
   assign frame_count   = cnt_q;

endmodule

// File: doc/pixel_frame_scheduler.md
Name: pixel_frame_scheduler

Overview:
- Ping-pong image buffer and scheduler between the pixel loader (UART/stream side) and the inference sequencer.
- Holds two banks of PIXELS pixels. A bank is filled from the write stream while the other is read by the inference datapath.
- Issues one infer_start pulse per full bank and recycles the bank on infer_done.
- Lets frame N+1 load while frame N is classified.

Parameters:
PIXELS, 784, pixels per frame (28x28)
DATA_W, 8, pixel width in bits
ADDR_W, 12, pixel address width; must satisfy 2^ADDR_W > PIXELS
CNT_W, 8, width of the completed-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of bank states and pointers; RAM contents and frame_count are kept
wr_valid  in  1  write-stream pixel valid
wr_data  in  DATA_W  write-stream pixel value
wr_ready  out  1  scheduler can accept a pixel this cycle
wr_frame_done  out  1  one-cycle pulse: a bank has just become FULL
infer_start  out  1  one-cycle pulse: bank rd_bank is ready for the inference sequencer
infer_done  in  1  one-cycle pulse from the inference sequencer: frame consumed
rd_addr  in  ADDR_W  pixel address from the inference datapath
rd_data  out  DATA_W  pixel at rd_addr of bank rd_bank, registered
rd_bank  out  1  bank currently owned or next to be owned by the reader
frame_count  out  CNT_W  number of completed inferences, wraps modulo 2^CNT_W

Behaviour:
- Bank state per bank, 2 bits: EMPTY, FILLING, FULL, READING.
- Reset (rst=1 at an edge) sets:
  - both banks EMPTY
  - wr_bank=0, wr_addr=0, rd_bank=0, reader state R_IDLE
  - wr_frame_done=0, infer_start=0, rd_data=0, frame_count=0
- wr_ready is forced 0 while rst or flush is high. Reset takes priority over flush, and flush over all other activity.
- Writer, pointer wr_bank with counter wr_addr (0..PIXELS-1):
  - wr_ready = bank[wr_bank] is EMPTY or FILLING. Combinational from registered state only, never from wr_valid.
  - Handshake is wr_valid & wr_ready. On a handshake, write RAM[wr_bank][wr_addr] = wr_data and mark the bank FILLING.
  - If wr_addr < PIXELS-1, increment wr_addr.
  - If wr_addr == PIXELS-1: bank becomes FULL, wr_addr returns to 0, wr_bank toggles, and wr_frame_done is high the next cycle for exactly one cycle.
  - wr_valid without wr_ready is ignored and nothing is written. The source must hold its data.
- Reader FSM:
  - R_IDLE: if bank[rd_bank]==FULL, set it READING, pulse infer_start, go to R_RUN. infer_done is ignored in R_IDLE.
  - R_RUN: on infer_done, set bank[rd_bank] EMPTY, toggle rd_bank, increment frame_count, go to R_IDLE.
  - Timing: last-pixel handshake in cycle t -> bank FULL in cycle t+1 -> infer_start high in cycle t+2.
  - Back-to-back frames: a frame already FULL on the other bank starts 2 cycles after infer_done (R_IDLE, then the pulse).
- Read port:
  - rd_data = RAM[rd_bank][rd_addr], 1-cycle latency.
  - rd_addr >= PIXELS returns 0 and has no side effects.
  - The read is valid regardless of reader state, so the sequencer may prefetch.
- Boundaries:
  - Both banks FULL or READING: wr_ready=0.
  - A bank freed by infer_done in cycle t accepts pixels from cycle t+1. There is no same-cycle bypass.
  - Writer and reader never target the same bank; this is guaranteed by state, with no address comparison needed.
  - A partially filled bank stays FILLING indefinitely. There is no timeout.
  - frame_count wraps from 2^CNT_W-1 to 0.
  - rst or flush mid-frame: the partial frame is discarded, any outstanding inference is abandoned, and a later infer_done is ignored because the reader is in R_IDLE.
  - infer_done and flush in the same cycle: flush wins and frame_count does not increment.

Decomposition:
- Package pixel_sched_pkg holds:
  - the PIXELS default
  - the bank-state encoding (EMPTY=0, FILLING=1, FULL=2, READING=3)
  - the reader-state encoding (R_IDLE, R_RUN)
- Sub-module pixel_bank_ram: 2 x PIXELS x DATA_W simple dual-port synchronous RAM, one write port and one registered read port, bank bit as address MSB, no reset on the array.
- The scheduler FSMs, counters and out-of-range read masking stay in pixel_frame_scheduler.

Test Plan:
- Reset, then stream 784 pixels with value = addr[7:0] and wr_valid held high:
  - wr_frame_done pulses once in the cycle after the last handshake.
  - infer_start pulses one cycle later with rd_bank=0.
  - rd_addr=5 returns 5 and rd_addr=783 returns 15 after 1 cycle; rd_addr=800 returns 0.
- Stream three frames back-to-back while infer_done is withheld:
  - wr_ready drops after pixel 1568.
  - Pulse infer_done: frame_count=1, rd_bank=1, infer_start 2 cycles later, wr_ready high the cycle after infer_done.
- Stall: toggle wr_valid every other cycle and then hold wr_valid low while wr_ready=0; verify no RAM writes and that the pixel count still ends at exactly 784 per frame.
- Flush after 400 pixels of frame 0:
  - wr_ready goes low for the flush cycle.
  - The next 784 pixels refill bank 0 from address 0, and infer_start fires once.
  - frame_count is unchanged.
- Assert rst during R_RUN:
  - All outputs return to their reset values and frame_count=0.
  - A subsequent infer_done is ignored (frame_count stays 0, no infer_start).
- Issue 256 complete frame/infer_done cycles with CNT_W=8: frame_count wraps to 0 and banks alternate 0,1,0,1.
